onn_phase_seq: RTL and testbench

- Initiator/sequencer that drives the reset, drop and phase-check trigger pulses into an array of N phase registers.
- Collects each register's state_changed flag after every check and declares convergence or timeout for the oscillatory network run.
- Sits between the top-level run control and the phase-register array; it is the driving end of the re/drop/state_cheak trigger interface.

---
 rtl/onn_pkg.sv | 25 ++
 rtl/onn_phase_seq_if.sv | 14 +
 rtl/onn_popcount.sv | 28 ++
 rtl/onn_phase_seq.sv | 155 +++++++++++++++
 tb/tb_onn_phase_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onn_pkg.sv
// Shared constants, FSM encoding and width helper for the ONN phase-register sequencer.
package onn_pkg;

    localparam int unsigned N_DEF            = 16;
    localparam int unsigned PULSE_W_DEF      = 2;
    localparam int unsigned CHECK_PERIOD_DEF = 64;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RST  = 4'd1,
        S_GAP  = 4'd2,
        S_DROP = 4'd3,
        S_WAIT = 4'd4,
        S_CHK  = 4'd5,
        S_SMP  = 4'd6,
        S_EVAL = 4'd7,
        S_FIN  = 4'd8
    } state_e;

    // Bits needed to hold a count of 0..n (never less than 1).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/onn_phase_seq_if.sv
// Trigger/flag interface between the sequencer (master) and the phase-register array (slave).
interface onn_phase_seq_if
    import onn_pkg::*;
#(
    parameter int unsigned N = N_DEF
);
    logic         re_o;
    logic         drop_o;
    logic         check_o;
    logic [N-1:0] state_changed_vec;

    modport master (output re_o, drop_o, check_o, input  state_changed_vec);
    modport slave  (input  re_o, drop_o, check_o, output state_changed_vec);
endinterface

// File: rtl/onn_popcount.sv
// Combinational popcount built as a balanced binary adder tree over a padded leaf array.
module onn_popcount
    import onn_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic [N-1:0]          vec_i,
    output logic [cnt_w(N)-1:0]   cnt_o
);
    localparam int unsigned CW     = cnt_w(N);
    localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 0;
    localparam int unsigned LEAVES = 1 << LEVELS;

    // Heap layout: node 0 is the root, leaves start at LEAVES-1.
    logic [CW-1:0] node [2*LEAVES-1];

    always_comb begin
        for (int i = 0; i < int'(LEAVES); i++) begin
            node[int'(LEAVES) - 1 + i] = (i < int'(N)) ? CW'(vec_i[i]) : '0;
        end
        for (int i = int'(LEAVES) - 2; i >= 0; i--) begin
            node[i] = node[2*i + 1] + node[2*i + 2];
        end
    end

    assign cnt_o = node[0];

endmodule

// File: rtl/onn_phase_seq.sv
// Drives re/drop/check trigger pulses into the phase-register array and decides
// convergence or timeout from the state_changed flags sampled after each check.
module onn_phase_seq
    import onn_pkg::*;
#(
    parameter int unsigned N             = N_DEF,
    parameter int unsigned PULSE_W       = PULSE_W_DEF,
    parameter int unsigned CHECK_PERIOD  = CHECK_PERIOD_DEF,
    parameter int unsigned SAMPLE_DLY    = 2,
    parameter int unsigned STABLE_CHECKS = 3,
    parameter int unsigned MAX_CHECKS    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    onn_phase_seq_if.master       trig,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic                  timeout,
    output logic [7:0]            check_count,
    output logic [cnt_w(N)-1:0]   changed_count
);
    localparam int unsigned CHG_W   = cnt_w(N);
    localparam int unsigned DLY_A   = (PULSE_W > CHECK_PERIOD) ? PULSE_W : CHECK_PERIOD;
    localparam int unsigned DLY_MAX = (DLY_A > SAMPLE_DLY) ? DLY_A : SAMPLE_DLY;
    localparam int unsigned TMR_W   = $clog2(DLY_MAX + 1);
    localparam int unsigned STB_W   = cnt_w(STABLE_CHECKS);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [STB_W-1:0]   stb_q, stb_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CHG_W-1:0]   chg_q, chg_d;
    logic               conv_q, conv_d;
    logic               tmo_q, tmo_d;
    logic               re_q, re_d;
    logic               drop_q, drop_d;
    logic               chk_q, chk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CHG_W-1:0]   pop;
    logic               tmr_zero;

    onn_popcount #(.N(N)) u_popcount (
        .vec_i (trig.state_changed_vec),
        .cnt_o (pop)
    );

    assign tmr_zero = (tmr_q == '0);

    // Next-state, shared delay timer and run bookkeeping.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_zero ? tmr_q : tmr_q - TMR_W'(1);
        stb_d   = stb_q;
        cnt_d   = cnt_q;
        chg_d   = chg_q;
        conv_d  = conv_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d = S_RST;
                tmr_d   = TMR_W'(PULSE_W - 1);
                stb_d   = '0;
                cnt_d   = '0;
                chg_d   = '0;
                conv_d  = 1'b0;
                tmo_d   = 1'b0;
            end
            S_RST:  if (tmr_zero) begin state_d = S_GAP;  tmr_d = TMR_W'(PULSE_W - 1);      end
            S_GAP:  if (tmr_zero) begin state_d = S_DROP; tmr_d = TMR_W'(PULSE_W - 1);      end
            S_DROP: if (tmr_zero) begin state_d = S_WAIT; tmr_d = TMR_W'(CHECK_PERIOD - 1); end
            S_WAIT: if (tmr_zero) begin state_d = S_CHK;  tmr_d = TMR_W'(PULSE_W - 1);      end
            S_CHK:  if (tmr_zero) begin state_d = S_SMP;  tmr_d = TMR_W'(SAMPLE_DLY - 1);   end
            S_SMP:  if (tmr_zero) state_d = S_EVAL;
            S_EVAL: begin
                chg_d = pop;
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                stb_d = (pop == '0) ? stb_q + STB_W'(1) : '0;
                if (stb_d == STB_W'(STABLE_CHECKS)) begin
                    state_d = S_FIN;
                    conv_d  = 1'b1;
                end else if (cnt_d == 8'(MAX_CHECKS)) begin
                    state_d = S_FIN;
                    tmo_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    tmr_d   = TMR_W'(CHECK_PERIOD - 1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything mid-run; the evaluation in flight is discarded.
        if (abort && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            state_d = S_IDLE;
            stb_d   = stb_q;
            cnt_d   = cnt_q;
            chg_d   = chg_q;
            conv_d  = 1'b0;
            tmo_d   = 1'b0;
        end

        re_d   = (state_d == S_RST);
        drop_d = (state_d == S_DROP);
        chk_d  = (state_d == S_CHK);
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            stb_q   <= '0;
            cnt_q   <= '0;
            chg_q   <= '0;
            conv_q  <= 1'b0;
            tmo_q   <= 1'b0;
            re_q    <= 1'b0;
            drop_q  <= 1'b0;
            chk_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            stb_q   <= stb_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
            conv_q  <= conv_d;
            tmo_q   <= tmo_d;
            re_q    <= re_d;
            drop_q  <= drop_d;
            chk_q   <= chk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign trig.re_o     = re_q;
    assign trig.drop_o   = drop_q;
    assign trig.check_o  = chk_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign converged     = conv_q;
    assign timeout       = tmo_q;
    assign check_count   = cnt_q;
    assign changed_count = chg_q;

endmodule

// File: tb/tb_onn_phase_seq.sv
// Scoreboard bench for onn_phase_seq: a main instance (MAX_CHECKS=10) and a
// priority instance (MAX_CHECKS=3) sharing clock and reset.
module tb_onn_phase_seq;
    import onn_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned PW  = 2;
    localparam int unsigned CP  = 8;
    localparam int unsigned SD  = 2;
    localparam int unsigned SC  = 3;
    localparam int unsigned MC  = 10;
    localparam int unsigned MC2 = 3;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int FIRST_EVAL   = 1 + 4*int'(PW) + int'(CP) + int'(SD);
    localparam int PERIOD       = int'(CP) + int'(PW) + int'(SD) + 1;

    typedef struct {
        bit conv;
        bit tmo;
        int cc;
        int chg;
        int done_cyc;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic          start [2];
    logic          abort [2];
    logic          busy  [2];
    logic          done  [2];
    logic          conv  [2];
    logic          tmo   [2];
    logic [7:0]    cc    [2];
    logic [CW-1:0] chg   [2];
    logic          re_w  [2];
    logic          drop_w[2];
    logic          chk_w [2];

    int   n_cmp;
    int   n_err;
    res_t exp_q[$];

    onn_phase_seq_if #(.N(N)) if0 ();
    onn_phase_seq_if #(.N(N)) if1 ();

    onn_phase_seq #(.N(N), .PULSE_W(PW), .CHECK_PERIOD(CP), .SAMPLE_DLY(SD),
                    .STABLE_CHECKS(SC), .MAX_CHECKS(MC)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .trig(if0.master),
        .busy(busy[0]), .done(done[0]), .converged(conv[0]), .timeout(tmo[0]),
        .check_count(cc[0]), .changed_count(chg[0]));

    onn_phase_seq #(.N(N), .PULSE_W(PW), .CHECK_PERIOD(CP), .SAMPLE_DLY(SD),
                    .STABLE_CHECKS(SC), .MAX_CHECKS(MC2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .trig(if1.master),
        .busy(busy[1]), .done(done[1]), .converged(conv[1]), .timeout(tmo[1]),
        .check_count(cc[1]), .changed_count(chg[1]));

    assign re_w[0]   = if0.re_o;
    assign re_w[1]   = if1.re_o;
    assign drop_w[0] = if0.drop_o;
    assign drop_w[1] = if1.drop_o;
    assign chk_w[0]  = if0.check_o;
    assign chk_w[1]  = if1.check_o;

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic set_flags(input int s, input logic [N-1:0] f);
        if (s == 0) if0.state_changed_vec = f;
        else        if1.state_changed_vec = f;
    endtask

    // Reference run outcome from a per-check flag list (last entry repeats).
    function automatic res_t model(input logic [N-1:0] fl[$], input int sc, input int mc);
        res_t r;
        int stb;
        int cnt;
        logic [N-1:0] f;
        r = '{default: 0};
        stb = 0;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            f = fl[(k < fl.size()) ? k : fl.size() - 1];
            cnt = (cnt == 255) ? 255 : cnt + 1;
            r.chg = $countones(f);
            stb = (r.chg == 0) ? stb + 1 : 0;
            if (stb == sc) begin r.conv = 1'b1; break; end
            if (cnt == mc) begin r.tmo = 1'b1; break; end
        end
        r.cc = cnt;
        r.done_cyc = FIRST_EVAL + PERIOD*(cnt - 1) + 1;
        return r;
    endfunction

    // Start a run and feed a new flag vector on every check rising edge until done.
    task automatic run(input int s, input logic [N-1:0] fl[$], input bit hold_start,
                       input int budget, output res_t obs, output bit got, output int re_rises);
        int j;
        logic prev_chk, prev_re;
        j = 0; got = 1'b0; re_rises = 0; prev_chk = 1'b0; prev_re = 1'b0;
        obs = '{default: 0};
        set_flags(s, '1);
        @(negedge clk);
        start[s] = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (!hold_start) start[s] = 1'b0;
            if (chk_w[s] && !prev_chk) begin
                set_flags(s, fl[(j < fl.size()) ? j : fl.size() - 1]);
                j++;
            end
            if (re_w[s] && !prev_re) re_rises++;
            prev_chk = chk_w[s];
            prev_re  = re_w[s];
            if (done[s]) begin
                got = 1'b1;
                obs.conv = conv[s]; obs.tmo = tmo[s];
                obs.cc = int'(cc[s]); obs.chg = int'(chg[s]); obs.done_cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if ({re_w[s], drop_w[s], chk_w[s], busy[s], done[s], conv[s], tmo[s]} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_flags dut%0d: re/drop/chk/busy/done/conv/tmo=%b expected 0000000", s,
                         {re_w[s], drop_w[s], chk_w[s], busy[s], done[s], conv[s], tmo[s]});
            end
            n_cmp++;
            if ({cc[s], chg[s]} !== '0) begin
                n_err++;
                $display("FAIL reset_counts dut%0d: check_count=%0d changed_count=%0d expected 0/0", s, cc[s], chg[s]);
            end
        end
    endtask

    task automatic test_nominal_timing();
        bit er, ed, ec;
        set_flags(0, '1);
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (k == 15) set_flags(0, 4'b0011);
            er = (k >= 1 && k <= 2);
            ed = (k >= 5 && k <= 6);
            ec = (k >= 15 && k <= 16) || (k >= 28 && k <= 29);
            n_cmp++;
            if ({re_w[0], drop_w[0], chk_w[0], busy[0]} !== {er, ed, ec, 1'b1}) begin
                n_err++;
                $display("FAIL nominal_timing cycle %0d: re/drop/chk/busy=%b expected %b", k,
                         {re_w[0], drop_w[0], chk_w[0], busy[0]}, {er, ed, ec, 1'b1});
            end
            if (k == FIRST_EVAL || k == FIRST_EVAL + 1) begin
                n_cmp++;
                if (cc[0] !== ((k == FIRST_EVAL) ? 8'd0 : 8'd1)) begin
                    n_err++;
                    $display("FAIL nominal_check_count cycle %0d: got %0d expected %0d", k, cc[0],
                             (k == FIRST_EVAL) ? 0 : 1);
                end
            end
        end
        n_cmp++;
        if (chg[0] !== CW'(2)) begin
            n_err++;
            $display("FAIL nominal_changed_count: got %0d expected 2", chg[0]);
        end
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        n_cmp++;
        if ({busy[0], chk_w[0], done[0]} !== 3'b000) begin
            n_err++;
            $display("FAIL nominal_abort_cleanup: busy/chk/done=%b expected 000", {busy[0], chk_w[0], done[0]});
        end
    endtask

    task automatic test_convergence();
        logic [N-1:0] fl[$];
        res_t e, o;
        bit got;
        int rr;
        fl = '{4'b0110, 4'b0000, 4'b0000, 4'b0000};
        exp_q.push_back(model(fl, SC, MC));
        run(0, fl, 1'b0, 300, o, got, rr);
        e = exp_q.pop_front();
        n_cmp++; if (!got) begin n_err++; $display("FAIL conv_done_seen: no done within budget, expected done"); end
        n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL conv_done_cycle: got %0d expected %0d", o.done_cyc, e.done_cyc); end
        n_cmp++; if ({o.conv, o.tmo} !== {e.conv, e.tmo}) begin n_err++; $display("FAIL conv_flags: conv/tmo=%b%b expected %b%b", o.conv, o.tmo, e.conv, e.tmo); end
        n_cmp++; if (o.cc !== e.cc || o.chg !== e.chg) begin n_err++; $display("FAIL conv_counts: cc=%0d chg=%0d expected %0d/%0d", o.cc, o.chg, e.cc, e.chg); end
        @(negedge clk);
        n_cmp++;
        if ({done[0], busy[0], conv[0]} !== {2'b00, e.conv}) begin
            n_err++;
            $display("FAIL conv_after_fin: done/busy/conv=%b expected 00%b", {done[0], busy[0], conv[0]}, e.conv);
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] fl[$];
        res_t e, o;
        bit got;
        int rr;
        fl = '{4'b0001};
        exp_q.push_back(model(fl, SC, MC));
        run(0, fl, 1'b0, 400, o, got, rr);
        e = exp_q.pop_front();
        n_cmp++; if (!got) begin n_err++; $display("FAIL tmo_done_seen: no done within budget, expected done"); end
        n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL tmo_done_cycle: got %0d expected %0d", o.done_cyc, e.done_cyc); end
        n_cmp++; if ({o.conv, o.tmo} !== {e.conv, e.tmo}) begin n_err++; $display("FAIL tmo_flags: conv/tmo=%b%b expected %b%b", o.conv, o.tmo, e.conv, e.tmo); end
        n_cmp++; if (o.cc !== e.cc || o.chg !== e.chg) begin n_err++; $display("FAIL tmo_counts: cc=%0d chg=%0d expected %0d/%0d", o.cc, o.chg, e.cc, e.chg); end
        @(negedge clk);
        n_cmp++;
        if ({done[0], busy[0], tmo[0]} !== {2'b00, e.tmo}) begin
            n_err++;
            $display("FAIL tmo_after_fin: done/busy/tmo=%b expected 00%b", {done[0], busy[0], tmo[0]}, e.tmo);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] fl[$];
        res_t e, o;
        bit got;
        int rr;
        fl = '{4'b0000};
        exp_q.push_back(model(fl, SC, MC2));
        run(1, fl, 1'b0, 300, o, got, rr);
        e = exp_q.pop_front();
        n_cmp++; if (!got) begin n_err++; $display("FAIL prio_done_seen: no done within budget, expected done"); end
        n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL prio_done_cycle: got %0d expected %0d", o.done_cyc, e.done_cyc); end
        n_cmp++; if ({o.conv, o.tmo} !== {e.conv, e.tmo}) begin n_err++; $display("FAIL prio_flags: conv/tmo=%b%b expected %b%b", o.conv, o.tmo, e.conv, e.tmo); end
        n_cmp++; if (o.cc !== e.cc || o.chg !== e.chg) begin n_err++; $display("FAIL prio_counts: cc=%0d chg=%0d expected %0d/%0d", o.cc, o.chg, e.cc, e.chg); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int nchk;
        bit seen;
        logic prev_chk;
        bit stray;
        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; abort[0] = 1'b0;
        n_cmp++;
        if ({busy[0], re_w[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_idle_start: busy/re=%b expected 00", {busy[0], re_w[0]});
        end
        set_flags(0, 4'b0001);
        start[0] = 1'b1;
        nchk = 0; seen = 1'b0; prev_chk = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (chk_w[0] && !prev_chk) nchk++;
            prev_chk = chk_w[0];
            if (nchk == 2) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL abort_second_check: check pulses seen=%0d expected 2", nchk); end
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        n_cmp++;
        if ({chk_w[0], re_w[0], drop_w[0], busy[0], done[0], conv[0], tmo[0]} !== 7'b0) begin
            n_err++;
            $display("FAIL abort_outputs: chk/re/drop/busy/done/conv/tmo=%b expected 0000000",
                     {chk_w[0], re_w[0], drop_w[0], busy[0], done[0], conv[0], tmo[0]});
        end
        n_cmp++;
        if (cc[0] !== 8'd1) begin n_err++; $display("FAIL abort_check_count: got %0d expected 1", cc[0]); end
        stray = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done[0] || busy[0] || re_w[0]) stray = 1'b1;
        end
        n_cmp++;
        if (stray) begin n_err++; $display("FAIL abort_quiet: activity after abort, expected none"); end
    endtask

    task automatic test_reset_mid_run();
        set_flags(0, '1);
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        n_cmp++;
        if (busy[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b expected 1", busy[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({re_w[0], drop_w[0], chk_w[0], busy[0], done[0], conv[0], tmo[0], cc[0], chg[0]} !== '0) begin
            n_err++;
            $display("FAIL rstmid_async: outputs=%b expected all 0",
                     {re_w[0], drop_w[0], chk_w[0], busy[0], done[0], conv[0], tmo[0], cc[0], chg[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            n_cmp++;
            if ({re_w[0], drop_w[0]} !== {1'(k <= 2), 1'(k >= 5 && k <= 6)}) begin
                n_err++;
                $display("FAIL rstmid_replay cycle %0d: re/drop=%b expected %b%b", k,
                         {re_w[0], drop_w[0]}, 1'(k <= 2), 1'(k >= 5 && k <= 6));
            end
        end
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
    endtask

    task automatic test_start_held();
        logic [N-1:0] fl[$];
        res_t e, o;
        bit got;
        int rr;
        fl = '{4'b0000};
        exp_q.push_back(model(fl, SC, MC));
        run(0, fl, 1'b1, 300, o, got, rr);
        e = exp_q.pop_front();
        n_cmp++; if (!got || o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL held_done_cycle: got %0d (seen=%0b) expected %0d", o.done_cyc, got, e.done_cyc); end
        n_cmp++; if (rr !== 1) begin n_err++; $display("FAIL held_re_pulses: got %0d expected 1", rr); end
        n_cmp++; if (o.conv !== e.conv || o.cc !== e.cc) begin n_err++; $display("FAIL held_result: conv=%b cc=%0d expected %b/%0d", o.conv, o.cc, e.conv, e.cc); end
        @(negedge clk);
        n_cmp++;
        if ({busy[0], re_w[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL held_idle_gap: busy/re=%b expected 00", {busy[0], re_w[0]});
        end
        @(negedge clk);
        start[0] = 1'b0;
        n_cmp++;
        if ({busy[0], re_w[0], conv[0]} !== 3'b110) begin
            n_err++;
            $display("FAIL held_restart: busy/re/conv=%b expected 110", {busy[0], re_w[0], conv[0]});
        end
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL held_abort: busy=%b expected 0", busy[0]); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0;
            abort[s] = 1'b0;
        end
        if0.state_changed_vec = '0;
        if1.state_changed_vec = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_nominal_timing();
        test_convergence();
        test_timeout();
        test_priority();
        test_abort();
        test_reset_mid_run();
        test_start_held();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
